// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: issues word loads/stores to data memory over a
// valid/ready handshake, stalls upstream while busy, and registers writeback.
module stage4_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   alu_res,
  input  logic [DATA_WIDTH-1:0]   rs2_val,
  input  logic [REG_ID_WIDTH-1:0] rd_idx,
  input  logic                    mem_load_enable,
  input  logic                    mem_store_enable,
  input  logic                    reg_write_enable,
  output logic                    dmem_req_valid,
  output logic                    dmem_req_we,
  output logic [ADDR_WIDTH-1:0]   dmem_req_addr,
  output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  input  logic                    dmem_req_ready,
  input  logic                    dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
  output logic                    stall_out,
  output logic [DATA_WIDTH-1:0]   wb_data_out,
  output logic [REG_ID_WIDTH-1:0] wb_rd_idx_out,
  output logic                    wb_reg_write_enable_out,
  output logic [DATA_WIDTH-1:0]   forwarded_result,
  output logic                    misaligned_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_wbData;
  logic [REG_ID_WIDTH-1:0] r_wbRdIdx;
  logic                    r_wbWe;
  logic                    r_misaligned;

  logic w_memOp;
  logic w_misaligned;
  logic w_alignedOp;
  logic w_regWrite;

  assign w_memOp      = mem_load_enable | mem_store_enable;
  assign w_misaligned = w_memOp & (alu_res[1:0] != 2'b00);
  assign w_alignedOp  = w_memOp & (alu_res[1:0] == 2'b00);
  assign w_regWrite   = reg_write_enable & (rd_idx != '0);

  // Request fields come straight from the upstream inputs, which stay frozen while stalled.
  assign dmem_req_valid = ((r_state == IDLE) & w_alignedOp) | (r_state == REQ);
  assign dmem_req_we    = mem_store_enable & ~mem_load_enable;
  assign dmem_req_addr  = alu_res[ADDR_WIDTH-1:0];
  assign dmem_req_wdata = rs2_val;

  assign stall_out = dmem_req_valid | ((r_state == RESP) & ~dmem_resp_valid);

  assign wb_data_out             = r_wbData;
  assign wb_rd_idx_out           = r_wbRdIdx;
  assign wb_reg_write_enable_out = r_wbWe;
  assign forwarded_result        = r_wbData;
  assign misaligned_out          = r_misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wbData     <= '0;
      r_wbRdIdx    <= '0;
      r_wbWe       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_misaligned) begin
            r_misaligned <= 1'b1;
            r_wbWe       <= 1'b0;
            r_wbRdIdx    <= rd_idx;
            r_wbData     <= alu_res;
          end else if (w_alignedOp) begin
            r_wbWe  <= 1'b0;
            r_state <= dmem_req_ready ? RESP : REQ;
          end else begin
            r_wbData  <= alu_res;
            r_wbRdIdx <= rd_idx;
            r_wbWe    <= w_regWrite;
          end
        end
        REQ: begin
          r_wbWe <= 1'b0;
          if (dmem_req_ready) r_state <= RESP;
        end
        RESP: begin
          if (dmem_resp_valid) begin
            // Load wins when both enables are set, so only a pure store skips the register write.
            r_state   <= IDLE;
            r_wbRdIdx <= rd_idx;
            if (mem_load_enable) begin
              r_wbData <= dmem_resp_rdata;
              r_wbWe   <= w_regWrite;
            end else begin
              r_wbData <= alu_res;
              r_wbWe   <= 1'b0;
            end
          end else begin
            r_wbWe <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_mem.sv
// Bench for stage4_mem: directed scenarios with literal checks, plus a
// transaction-level model compared against the DUT on every negedge.
module tb_stage4_mem;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] aluRes, rs2Val, respRdata;
  logic [RW-1:0] rdIdx;
  logic          loadEn, storeEn, regWe, reqReady, respValid;
  logic          reqValid, reqWe, stall, wbWe, misaligned;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata, wbData, fwd;
  logic [RW-1:0] wbRd;

  int nChecks = 0;
  int nFails  = 0;

  stage4_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ID_WIDTH(RW)) dut (
    .clk(clk), .reset(reset),
    .alu_res(aluRes), .rs2_val(rs2Val), .rd_idx(rdIdx),
    .mem_load_enable(loadEn), .mem_store_enable(storeEn), .reg_write_enable(regWe),
    .dmem_req_valid(reqValid), .dmem_req_we(reqWe), .dmem_req_addr(reqAddr),
    .dmem_req_wdata(reqWdata), .dmem_req_ready(reqReady),
    .dmem_resp_valid(respValid), .dmem_resp_rdata(respRdata),
    .stall_out(stall), .wb_data_out(wbData), .wb_rd_idx_out(wbRd),
    .wb_reg_write_enable_out(wbWe), .forwarded_result(fwd),
    .misaligned_out(misaligned)
  );

  always #5 clk = ~clk;

  // Transaction model: an access is either waiting for acceptance or for its response.
  bit            mWaitAccept, mWaitResp, mMis, mWbWe;
  logic [DW-1:0] mWbData;
  logic [RW-1:0] mWbRd;

  function automatic bit isOp();
    return loadEn || storeEn;
  endfunction

  function automatic bit isAligned();
    return aluRes % 4 == 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mWaitAccept = 0; mWaitResp = 0; mMis = 0;
      mWbWe = 0; mWbData = '0; mWbRd = '0;
    end else begin
      mMis = 0;
      if (mWaitResp && respValid) begin
        mWaitResp = 0;
        mWbRd = rdIdx;
        mWbData = loadEn ? respRdata : aluRes;
        mWbWe = loadEn && regWe && rdIdx != 0;
      end else if (mWaitResp || mWaitAccept) begin
        mWbWe = 0;
        if (mWaitAccept && reqReady) begin
          mWaitAccept = 0;
          mWaitResp = 1;
        end
      end else if (isOp() && !isAligned()) begin
        mMis = 1; mWbWe = 0; mWbRd = rdIdx; mWbData = aluRes;
      end else if (isOp()) begin
        mWbWe = 0;
        if (reqReady) mWaitResp = 1;
        else mWaitAccept = 1;
      end else begin
        mWbData = aluRes; mWbRd = rdIdx; mWbWe = regWe && rdIdx != 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  bit started = 0;

  always @(negedge clk) begin
    bit expReq, expStall;
    if (started && !reset) begin
      expReq   = mWaitAccept || (!mWaitResp && isOp() && isAligned());
      expStall = expReq || (mWaitResp && !respValid);
      checkOutput("model req_valid", {31'b0, reqValid}, {31'b0, expReq});
      checkOutput("model stall", {31'b0, stall}, {31'b0, expStall});
      if (expReq) begin
        checkOutput("model req_we", {31'b0, reqWe}, {31'b0, storeEn && !loadEn});
        checkOutput("model req_addr", reqAddr, aluRes);
        checkOutput("model req_wdata", reqWdata, rs2Val);
      end
      checkOutput("model wb_data", wbData, mWbData);
      checkOutput("model wb_rd", {27'b0, wbRd}, {27'b0, mWbRd});
      checkOutput("model wb_we", {31'b0, wbWe}, {31'b0, mWbWe});
      checkOutput("model forward", fwd, mWbData);
      checkOutput("model misaligned", {31'b0, misaligned}, {31'b0, mMis});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] alu, input logic [DW-1:0] rs2,
                               input logic [RW-1:0] rd, input logic ld,
                               input logic st, input logic we);
    aluRes = alu; rs2Val = rs2; rdIdx = rd; loadEn = ld; storeEn = st; regWe = we;
  endtask

  initial begin
    int stallCount;
    reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    reqReady = 0; respValid = 0; respRdata = 0;
    cycle(); cycle();
    checkOutput("reset wb_data", wbData, 32'h0);
    checkOutput("reset wb_we", {31'b0, wbWe}, 32'h0);
    checkOutput("reset stall", {31'b0, stall}, 32'h0);
    checkOutput("reset req_valid", {31'b0, reqValid}, 32'h0);
    reset = 0;
    started = 1;

    // ALU pass-through
    applyStimulus(32'h1234, 0, 5, 0, 0, 1);
    #1 checkOutput("pass stall", {31'b0, stall}, 32'h0);
    cycle();
    checkOutput("pass wb_data", wbData, 32'h1234);
    checkOutput("pass wb_rd", {27'b0, wbRd}, 32'd5);
    checkOutput("pass wb_we", {31'b0, wbWe}, 32'h1);

    // Load, ready immediately, response next cycle
    applyStimulus(32'h100, 0, 3, 1, 0, 1);
    reqReady = 1;
    #1;
    checkOutput("load c0 req_valid", {31'b0, reqValid}, 32'h1);
    checkOutput("load c0 req_we", {31'b0, reqWe}, 32'h0);
    checkOutput("load c0 stall", {31'b0, stall}, 32'h1);
    cycle();
    reqReady = 0; respValid = 1; respRdata = 32'hDEADBEEF;
    #1 checkOutput("load c1 stall", {31'b0, stall}, 32'h0);
    cycle();
    respValid = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("load wb_data", wbData, 32'hDEADBEEF);
    checkOutput("load wb_rd", {27'b0, wbRd}, 32'd3);
    checkOutput("load wb_we", {31'b0, wbWe}, 32'h1);
    cycle();
    checkOutput("load wb_we one cycle", {31'b0, wbWe}, 32'h0);

    // Store, ready low for 3 cycles, response after two waiting cycles
    applyStimulus(32'h40, 32'hA5A5A5A5, 9, 0, 1, 1);
    stallCount = 0;
    for (int i = 0; i < 4; i++) begin
      reqReady = (i == 3);
      #1;
      checkOutput("store req_valid", {31'b0, reqValid}, 32'h1);
      checkOutput("store req_addr", reqAddr, 32'h40);
      checkOutput("store req_wdata", reqWdata, 32'hA5A5A5A5);
      checkOutput("store req_we", {31'b0, reqWe}, 32'h1);
      if (stall) stallCount++;
      cycle();
      checkOutput("store wb_we", {31'b0, wbWe}, 32'h0);
    end
    reqReady = 0;
    for (int i = 0; i < 3; i++) begin
      respValid = (i == 2);
      #1;
      if (stall) stallCount++;
      cycle();
      checkOutput("store resp wb_we", {31'b0, wbWe}, 32'h0);
    end
    respValid = 0;
    checkOutput("store stall cycles", stallCount, 32'd6);
    checkOutput("store wb_data", wbData, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycle();

    // Misaligned load
    applyStimulus(32'h102, 0, 7, 1, 0, 1);
    reqReady = 1;
    #1;
    checkOutput("mis req_valid", {31'b0, reqValid}, 32'h0);
    checkOutput("mis stall", {31'b0, stall}, 32'h0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    reqReady = 0;
    checkOutput("mis pulse", {31'b0, misaligned}, 32'h1);
    checkOutput("mis wb_we", {31'b0, wbWe}, 32'h0);
    checkOutput("mis wb_rd", {27'b0, wbRd}, 32'd7);
    checkOutput("mis wb_data", wbData, 32'h102);
    cycle();
    checkOutput("mis pulse end", {31'b0, misaligned}, 32'h0);

    // Load to x0
    applyStimulus(32'h200, 0, 0, 1, 0, 1);
    reqReady = 1;
    cycle();
    reqReady = 0; respValid = 1; respRdata = 32'h55AA;
    cycle();
    respValid = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("x0 wb_data", wbData, 32'h55AA);
    checkOutput("x0 wb_we", {31'b0, wbWe}, 32'h0);

    // Load+store together: load wins
    applyStimulus(32'h80, 32'h99, 4, 1, 1, 1);
    reqReady = 1;
    #1 checkOutput("both req_we", {31'b0, reqWe}, 32'h0);
    cycle();
    reqReady = 0; respValid = 1; respRdata = 32'h77;
    cycle();
    respValid = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("both wb_data", wbData, 32'h77);
    checkOutput("both wb_we", {31'b0, wbWe}, 32'h1);

    // Reset while waiting for a response, then a spurious response while idle
    applyStimulus(32'h300, 0, 6, 1, 0, 1);
    reqReady = 1;
    cycle();
    reqReady = 0;
    #1 reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst wb_data", wbData, 32'h0);
    checkOutput("rst wb_we", {31'b0, wbWe}, 32'h0);
    checkOutput("rst stall", {31'b0, stall}, 32'h0);
    cycle();
    reset = 0;
    respValid = 1; respRdata = 32'hBAD0BAD0;
    #1 checkOutput("spurious stall", {31'b0, stall}, 32'h0);
    cycle();
    respValid = 0;
    checkOutput("spurious wb_we", {31'b0, wbWe}, 32'h0);
    checkOutput("spurious wb_data", wbData, 32'h0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stage4_mem.md
Name: stage4_mem

Overview:
- Memory-access pipeline stage. It sits directly downstream of the execute stage and upstream of register writeback.
- It consumes the registered execute outputs (ALU result, rs2 value, rd index, load/store/write enables). It issues word loads and stores to the data memory over a valid/ready request and response handshake.
- It stalls the upstream pipeline while an access is outstanding, registers the writeback bundle, and provides the forwarding value to execute.

Parameters:
- DATA_WIDTH, 32, width of data words and rs2 store data
- ADDR_WIDTH, 32, width of data-memory addresses; taken from alu_res[ADDR_WIDTH-1:0]
- REG_ID_WIDTH, 5, width of the register index

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_res  in  DATA_WIDTH  ALU result; the memory address for loads and stores
- rs2_val  in  DATA_WIDTH  store data
- rd_idx  in  REG_ID_WIDTH  destination register
- mem_load_enable  in  1  load request
- mem_store_enable  in  1  store request
- reg_write_enable  in  1  destination write request
- dmem_req_valid  out  1  request valid
- dmem_req_we  out  1  1 = store, 0 = load
- dmem_req_addr  out  ADDR_WIDTH  word address
- dmem_req_wdata  out  DATA_WIDTH  store data
- dmem_req_ready  in  1  memory accepts the request
- dmem_resp_valid  in  1  load data or store acknowledge
- dmem_resp_rdata  in  DATA_WIDTH  load data
- stall_out  out  1  combinational; upstream holds all inputs stable while high
- wb_data_out  out  DATA_WIDTH  registered writeback value
- wb_rd_idx_out  out  REG_ID_WIDTH  registered destination index
- wb_reg_write_enable_out  out  1  registered write strobe
- forwarded_result  out  DATA_WIDTH  equals wb_data_out; feeds the execute-stage forwarding mux
- misaligned_out  out  1  registered one-cycle pulse on a misaligned access

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset: state = IDLE; all registered outputs are 0; dmem_req_valid = 0; stall_out = 0.
- Reset mid-access abandons the access. The data memory shares the same reset, so no stale response survives reset.
- A memory op is mem_load_enable | mem_store_enable.
  - If both are set, the op is a load (load wins) and no write is issued.
- Misaligned access: a memory op with alu_res[1:0] != 0.
  - No request is issued and there is no stall.
  - Next edge: misaligned_out = 1, wb_reg_write_enable_out = 0, wb_rd_idx_out = rd_idx, wb_data_out = alu_res.
- FSM states: IDLE, REQ, RESP.
- IDLE with an aligned memory op:
  - Drive dmem_req_valid = 1, dmem_req_we = store (and not load), dmem_req_addr = alu_res, dmem_req_wdata = rs2_val.
  - stall_out = 1.
  - Next state: RESP if dmem_req_ready, else REQ.
- REQ: hold the request outputs, which come from the stable inputs; stall_out = 1. Go to RESP when dmem_req_ready is sampled high.
- RESP: dmem_req_valid = 0.
  - If dmem_resp_valid: stall_out = 0 in that same cycle; at the edge, state goes to IDLE and the writeback registers load.
  - Otherwise: stall_out = 1.
- Writeback register loads on a completing access:
  - Load: wb_data_out = dmem_resp_rdata; wb_reg_write_enable_out = reg_write_enable & (rd_idx != 0).
  - Store: wb_data_out = alu_res; wb_reg_write_enable_out = 0.
- IDLE with no memory op, every edge: wb_data_out = alu_res, wb_rd_idx_out = rd_idx, wb_reg_write_enable_out = reg_write_enable & (rd_idx != 0). Latency is 1 cycle.
- Bubble on stall: every edge with stall_out = 1 loads wb_reg_write_enable_out = 0, so there are no duplicate writes. wb_data_out and wb_rd_idx_out hold.
- dmem_resp_valid seen in IDLE or REQ is ignored.
- Minimum access latency is 2 cycles: request accepted in cycle 0, response in cycle 1. Writeback is visible after the completing edge.
- A back-to-back memory op following a completed access starts in IDLE on the next cycle. There are no idle gap cycles beyond the FSM return.
- misaligned_out is 0 on every cycle other than the pulse.

Test Plan:
- ALU pass-through, no memory op: alu_res=0x1234, rd=5, we=1 -> next edge wb_data_out=0x1234, wb_rd_idx_out=5, wb_reg_write_enable_out=1, stall_out=0 throughout.
- Load with ready=1 and response one cycle later: addr 0x100, resp_rdata=0xDEADBEEF, rd=3.
  - Cycle 0: dmem_req_valid=1, we=0, stall_out=1.
  - Cycle 1: stall_out=0.
  - After edge 1: wb_data_out=0xDEADBEEF, wb_reg_write_enable_out=1 for exactly one cycle.
- Store with ready low for 3 cycles and resp 2 cycles after acceptance: addr 0x40, rs2=0xA5A5A5A5.
  - Request held stable for 4 cycles; stall_out=1 for 6 cycles.
  - wb_reg_write_enable_out=0 throughout.
- Misaligned load at addr 0x102, rd=7 -> no dmem_req_valid; misaligned_out=1 for one cycle; wb_reg_write_enable_out=0.
- Load to rd=0 -> access completes normally; wb_reg_write_enable_out stays 0.
- Reset asserted in RESP, then released -> outputs 0, state IDLE. A spurious resp_valid=1 while idle produces no writeback.
